// File: rtl/hamming_weight_acc.sv
// ---------------------------------------------------------------------------
// hamming_weight_acc
//
// Streaming frame-level Hamming weight accumulator. Each accepted word is
// population-counted (ones, or zeros when in_count_zeros is set) into a
// registered stage S1. Non-last words then fold into a saturating frame
// accumulator. The last word of a frame folds in and the totals go to an
// output register, which holds until downstream consumes them.
//
// Parameters
//   DATA_WIDTH : input word width in bits (power of two, >= 8)
//   ACC_WIDTH  : width of the frame weight accumulator and the word counter
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   in_valid       : input word valid
//   in_ready       : block can accept a word this cycle
//   in_data        : word to weigh
//   in_last        : final word of the frame
//   in_count_zeros : 1 = count zero bits of this word, 0 = count one bits
//   out_valid      : frame result valid
//   out_ready      : downstream accepts the result
//   out_weight     : total frame weight, saturated
//   out_words      : number of words in the frame, saturated
//   out_sat        : weight or word count clamped during the frame
// ---------------------------------------------------------------------------
module hamming_weight_acc #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_count_zeros,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_weight,
  output logic [ACC_WIDTH-1:0]  out_words,
  output logic                  out_sat
);

  localparam int LEVELS          = $clog2(DATA_WIDTH);
  localparam int WORD_WEIGHT_LEN = LEVELS + 1;
  // Zero padding that widens a per-word weight to the accumulator sum width.
  localparam int PAD_WIDTH       = ACC_WIDTH + 1 - WORD_WEIGHT_LEN;

  // -------------------------------------------------------------------------
  // Population count: balanced adder tree. Level gi holds DATA_WIDTH>>gi
  // partial sums, each gi+1 bits wide, so no level carries excess width.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]      pc_src;
  logic [WORD_WEIGHT_LEN-1:0] word_weight;

  assign pc_src = in_count_zeros ? ~in_data : in_data;

  genvar gi, gj;
  generate
    for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
      localparam int NODES = DATA_WIDTH >> gi;
      logic [gi:0] node [NODES];
      if (gi == 0) begin : g_leaf
        for (gj = 0; gj < NODES; gj++) begin : g_bit
          assign node[gj] = pc_src[gj];
        end
      end else begin : g_add
        for (gj = 0; gj < NODES; gj++) begin : g_pair
          assign node[gj] = {1'b0, g_lvl[gi-1].node[2*gj]}
                          + {1'b0, g_lvl[gi-1].node[2*gj+1]};
        end
      end
    end
  endgenerate

  assign word_weight = g_lvl[LEVELS].node[0];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                       s1_valid_q,  s1_valid_d;
  logic [WORD_WEIGHT_LEN-1:0] s1_weight_q, s1_weight_d;
  logic                       s1_last_q,   s1_last_d;
  logic [ACC_WIDTH-1:0]       acc_q,       acc_d;
  logic [ACC_WIDTH-1:0]       cnt_q,       cnt_d;
  logic                       sat_q,       sat_d;
  logic                       out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]       out_weight_q, out_weight_d;
  logic [ACC_WIDTH-1:0]       out_words_q,  out_words_d;
  logic                       out_sat_q,    out_sat_d;

  // -------------------------------------------------------------------------
  // Handshake and saturating sums
  // -------------------------------------------------------------------------
  logic                 out_free;
  logic                 s1_adv;
  logic                 accept;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH:0]   cnt_sum;
  logic                 acc_clamp;
  logic                 cnt_clamp;
  logic [ACC_WIDTH-1:0] acc_sat;
  logic [ACC_WIDTH-1:0] cnt_sat;

  // The output register can take a new result if empty or emptying now.
  assign out_free = ~out_valid_q | out_ready;
  // Non-last words always drain into the accumulator; a last word needs room.
  assign s1_adv   = s1_valid_q & (~s1_last_q | out_free);
  assign in_ready = ~s1_valid_q | s1_adv;
  assign accept   = in_valid & in_ready;

  // One extra bit catches the overflow that triggers clamping.
  assign acc_sum   = {1'b0, acc_q} + {{PAD_WIDTH{1'b0}}, s1_weight_q};
  assign cnt_sum   = {1'b0, cnt_q} + {{ACC_WIDTH{1'b0}}, 1'b1};
  assign acc_clamp = acc_sum[ACC_WIDTH];
  assign cnt_clamp = cnt_sum[ACC_WIDTH];
  assign acc_sat   = acc_clamp ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];
  assign cnt_sat   = cnt_clamp ? {ACC_WIDTH{1'b1}} : cnt_sum[ACC_WIDTH-1:0];

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_weight_d  = s1_weight_q;
    s1_last_d    = s1_last_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    sat_d        = sat_q;
    out_valid_d  = out_valid_q;
    out_weight_d = out_weight_q;
    out_words_d  = out_words_q;
    out_sat_d    = out_sat_q;

    // Stage 1 load / drain.
    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_weight_d = word_weight;
      s1_last_d   = in_last;
    end else if (s1_adv) begin
      s1_valid_d  = 1'b0;
    end

    // Result consumed; a fresh load below overrides this in the same edge.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Stage 2: accumulate, or close the frame.
    if (s1_adv) begin
      if (!s1_last_q) begin
        acc_d = acc_sat;
        cnt_d = cnt_sat;
        sat_d = sat_q | acc_clamp | cnt_clamp;
      end else begin
        out_valid_d  = 1'b1;
        out_weight_d = acc_sat;
        out_words_d  = cnt_sat;
        out_sat_d    = sat_q | acc_clamp | cnt_clamp;
        acc_d        = '0;
        cnt_d        = '0;
        sat_d        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_weight_q  <= '0;
      s1_last_q    <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_weight_q <= '0;
      out_words_q  <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_weight_q  <= s1_weight_d;
      s1_last_q    <= s1_last_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sat_q        <= sat_d;
      out_valid_q  <= out_valid_d;
      out_weight_q <= out_weight_d;
      out_words_q  <= out_words_d;
      out_sat_q    <= out_sat_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_weight = out_weight_q;
  assign out_words  = out_words_q;
  assign out_sat    = out_sat_q;

endmodule

// File: tb/tb_hamming_weight_acc.sv
// ---------------------------------------------------------------------------
// tb_hamming_weight_acc
//
// Directed frames plus randomized traffic against a frame-level reference
// model (sum of $countones per word, clamped with min()). A negedge monitor
// scores every consumed result and checks that a held result never changes.
// ---------------------------------------------------------------------------
module tb_hamming_weight_acc;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int AMAX = (1 << AW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_count_zeros;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_weight;
  logic [AW-1:0] out_words;
  logic          out_sat;

  hamming_weight_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_count_zeros (in_count_zeros),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_weight     (out_weight),
    .out_words      (out_words),
    .out_sat        (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit rand_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model and scoreboard
  // ------------------------------------------------------------------
  typedef struct {
    int w;
    int n;
    bit s;
  } res_t;

  res_t        exp_q[$];
  int          cur_w = 0;
  int          cur_n = 0;
  bit          hold_prev = 0;
  logic [17:0] snap;
  int          n_results = 0;

  always @(negedge clk) begin
    res_t e;
    int   wt;
    if (rst) begin
      exp_q.delete();
      cur_w     = 0;
      cur_n     = 0;
      hold_prev = 0;
    end else begin
      if (hold_prev)
        check("hold_stable", {out_valid, out_weight, out_words, out_sat}, snap);
      if (out_valid && out_ready) begin
        check("sb_nonempty", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_weight", out_weight, e.w);
          check("sb_words", out_words, e.n);
          check("sb_sat", out_sat, e.s);
          n_results++;
          $display("result %0d: weight=%0d words=%0d sat=%0d", n_results, out_weight, out_words, out_sat);
        end
      end
      if (in_valid && in_ready) begin
        wt = $countones(in_count_zeros ? ~in_data : in_data);
        cur_w += wt;
        cur_n += 1;
        if (in_last) begin
          e.w = (cur_w > AMAX) ? AMAX : cur_w;
          e.n = (cur_n > AMAX) ? AMAX : cur_n;
          e.s = (cur_w > AMAX) || (cur_n > AMAX);
          exp_q.push_back(e);
          cur_w = 0;
          cur_n = 0;
        end
      end
      hold_prev = out_valid && !out_ready;
      snap      = {out_valid, out_weight, out_words, out_sat};
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic tick_ready();
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic z, input logic l);
    bit done = 0;
    if (rand_mode) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        tick_ready();
      end
    end
    in_valid       = 1'b1;
    in_data        = d;
    in_count_zeros = z;
    in_last        = l;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
      tick_ready();
    end
    in_valid = 1'b0;
    check("send_accept", done, 1);
  endtask

  // Waits (bounded) for a result with out_ready=1 and checks it.
  task automatic expect_result(input string tag, input int w, input int n, input bit s);
    bit found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    check({tag, "_seen"}, found, 1);
    check({tag, "_weight"}, out_weight, w);
    check({tag, "_words"}, out_words, n);
    check({tag, "_sat"}, out_sat, s);
    @(posedge clk); #1;
  endtask

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_count_zeros = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_weight", out_weight, 0);
    check("rst_out_words", out_words, 0);
    check("rst_out_sat", out_sat, 0);
    @(posedge clk); #1;

    // Three-word frame, latency of two cycles after the last accept
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'h0000_000F, 1'b0, 1'b0);
    send(32'h8000_0001, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_t1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_t2_valid", out_valid, 1);
    check("f1_weight", out_weight, 38);
    check("f1_words", out_words, 3);
    check("f1_sat", out_sat, 0);
    @(posedge clk); #1;

    // Zero counting versus one counting on an all-zero word
    send(32'h0, 1'b1, 1'b1);
    expect_result("zeros", 32, 1, 0);
    send(32'h0, 1'b0, 1'b1);
    expect_result("ones", 0, 1, 0);

    // Weight saturation, then flag cleared on the next frame
    for (int i = 0; i < 9; i++) send(32'hFFFF_FFFF, 1'b0, (i == 8));
    expect_result("wsat", AMAX, 9, 1);
    send(32'h1, 1'b0, 1'b1);
    expect_result("after_sat", 1, 1, 0);

    // Word-count saturation with zero weight
    for (int i = 0; i < 260; i++) send(32'h0, 1'b0, (i == 259));
    expect_result("nsat", 0, AMAX, 1);

    // Back-pressure: held result, stalled last word, ordered drain
    out_ready = 1'b0;
    send(32'h1, 1'b0, 1'b1);
    send(32'h3, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 32'h7; in_count_zeros = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_weight", out_weight, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("drain0_ready", in_ready, 1);
    check("drain0_weight", out_weight, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("drain1_valid", out_valid, 1);
    check("drain1_weight", out_weight, 2);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain2_valid", out_valid, 1);
    check("drain2_weight", out_weight, 3);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_done_valid", out_valid, 0);
    @(posedge clk); #1;

    // Asynchronous reset with a pending result and a partial frame
    out_ready = 1'b0;
    send(32'h1, 1'b0, 1'b1);
    send(32'h0000_00FF, 1'b0, 1'b0);
    send(32'h0000_0FFF, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_weight", out_weight, 0);
    check("arst_words", out_words, 0);
    check("arst_sat", out_sat, 0);
    check("arst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    send(32'h3, 1'b0, 1'b1);
    expect_result("post_rst", 2, 1, 0);

    // Randomized frames against the model
    rand_mode = 1;
    for (int f = 0; f < 1000; f++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        logic [DW-1:0] d;
        case ($urandom_range(0, 3))
          0:       d = 32'hFFFF_FFFF;
          1:       d = 32'h0;
          default: d = $urandom;
        endcase
        send(d, 1'(($urandom_range(0, 1))), (i == len - 1));
      end
    end
    rand_mode = 0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
